afe_spi_link: RTL and testbench

- Parametrised SPI master for the AFE serial link on the backplane board.
- Replaces the fixed, tied-off spi_clk_o/spi_mosi_o/spi_sel/sel0/sel1 wiring with a generalised engine. Supports configurable word width, select-line count, clock divider, bit order and latch pulse width.
- Takes one command per transfer from the register/DMA side through a valid/ready handshake. Shifts the word out, captures MISO in the same transfer, pulses the latch, then returns the captured word.

---
 rtl/afe_spi_pkg.sv | 23 ++
 rtl/afe_spi_link_clkgen.sv | 51 +++++
 rtl/afe_spi_link.sv | 164 ++++++++++++++++
 tb/tb_afe_spi_link.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/afe_spi_pkg.sv
// Shared types and helpers for the AFE SPI link: FSM state encoding,
// counter sizing and end-to-end transfer latency.
package afe_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_DONE  = 2'd3
    } afe_state_e;

    // Bits needed for a counter running 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Cycles from command acceptance to the rsp_valid pulse.
    function automatic int afe_spi_latency(input int data_w, input int clk_div,
                                           input int latch_cyc);
        return 1 + 2 * clk_div * data_w + latch_cyc;
    endfunction

endpackage

// File: rtl/afe_spi_link_clkgen.sv
// Half-period divider for the SPI clock. Runs only while enabled and
// parks at the start of a low phase otherwise.
module afe_spi_clkgen
    import afe_spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic phase_o,
    output logic toggle_o,
    output logic rise_o
);

    localparam int HW = cnt_w(CLK_DIV);

    logic [HW-1:0] hp_q, hp_d;
    logic          phase_q, phase_d;

    // toggle_o marks the last cycle of a half-period; rise_o is the subset
    // where the SPI clock is about to go 0->1.
    assign toggle_o = en_i && (hp_q == HW'(CLK_DIV - 1));
    assign rise_o   = toggle_o && !phase_q;
    assign phase_o  = phase_q;

    always_comb begin
        hp_d    = hp_q;
        phase_d = phase_q;
        if (!en_i) begin
            hp_d    = '0;
            phase_d = 1'b0;
        end else if (toggle_o) begin
            hp_d    = '0;
            phase_d = !phase_q;
        end else begin
            hp_d = hp_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hp_q    <= '0;
            phase_q <= 1'b0;
        end else begin
            hp_q    <= hp_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/afe_spi_link.sv
// SPI master for the AFE backplane link: one command in, one word shifted
// out while MISO is captured, latch strobe, then the captured word returned.
module afe_spi_link
    import afe_spi_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int N_SEL     = 2,
    parameter int CLK_DIV   = 2,
    parameter int LATCH_CYC = 2,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [N_SEL-1:0]  cmd_sel,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              spi_clk_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i,
    output logic              spi_sel,
    output logic [N_SEL-1:0]  sel_o
);

    localparam int BW      = cnt_w(DATA_W);
    localparam int LW      = cnt_w(LATCH_CYC);
    localparam int LATENCY = afe_spi_latency(DATA_W, CLK_DIV, LATCH_CYC);

    afe_state_e        state_q, state_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic [DATA_W-1:0] sh_q, sh_d, cap_q, cap_d, rdata_q, rdata_d;
    logic [N_SEL-1:0]  sel_q, sel_d;
    logic              mosi_q, mosi_d;
    logic              ready_q, valid_q, busy_q, latch_q;
    int                xfer_q, xfer_d;
    logic              phase, toggle, rise, fall, last_bit;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
    endfunction

    afe_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
        .en_i     (state_q == ST_SHIFT),
        .phase_o  (phase),
        .toggle_o (toggle),
        .rise_o   (rise)
    );

    assign fall     = toggle && phase;
    assign last_bit = (bit_q == BW'(DATA_W - 1));

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        lat_d   = '0;
        sh_d    = sh_q;
        cap_d   = cap_q;
        mosi_d  = mosi_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        xfer_d  = 0;
        unique case (state_q)
            ST_IDLE: begin
                bit_d = '0;
                if (cmd_valid) begin
                    state_d = ST_SHIFT;
                    sh_d    = cmd_wdata;
                    mosi_d  = first_bit(cmd_wdata);
                    sel_d   = cmd_sel;
                    cap_d   = '0;
                    xfer_d  = 1;
                end
            end
            ST_SHIFT: begin
                xfer_d = xfer_q + 1;
                if (rise) begin
                    cap_d = LSB_FIRST ? {spi_miso_i, cap_q[DATA_W-1:1]}
                                      : {cap_q[DATA_W-2:0], spi_miso_i};
                end
                // MOSI advances only when a high phase ends, i.e. at the
                // start of the next bit's low phase.
                if (fall) begin
                    if (last_bit) begin
                        state_d = ST_LATCH;
                        bit_d   = '0;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sh_d   = shift_word(sh_q);
                        mosi_d = first_bit(shift_word(sh_q));
                    end
                end
            end
            ST_LATCH: begin
                xfer_d = xfer_q + 1;
                if (lat_q == LW'(LATCH_CYC - 1)) begin
                    state_d = ST_DONE;
                    sel_d   = '0;
                    rdata_d = cap_q;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            lat_q   <= '0;
            sh_q    <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
            sel_q   <= '0;
            mosi_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            latch_q <= 1'b0;
            xfer_q  <= 0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            lat_q   <= lat_d;
            sh_q    <= sh_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
            sel_q   <= sel_d;
            mosi_q  <= mosi_d;
            ready_q <= (state_d == ST_IDLE);
            valid_q <= (state_d == ST_DONE);
            busy_q  <= (state_d != ST_IDLE);
            latch_q <= (state_d == ST_LATCH);
            xfer_q  <= xfer_d;
            if (state_q == ST_DONE) begin
                assert (xfer_q == LATENCY);
            end
        end
    end

    assign cmd_ready  = ready_q;
    assign rsp_valid  = valid_q;
    assign rsp_rdata  = rdata_q;
    assign busy       = busy_q;
    assign spi_clk_o  = phase;
    assign spi_mosi_o = mosi_q;
    assign spi_sel    = latch_q;
    assign sel_o      = sel_q;

endmodule

// File: tb/tb_afe_spi_link.sv
// Directed bench for afe_spi_link: three parameterisations driven from one
// sequence, each with a small SPI slave returning a fixed word.
module tb_afe_spi_link;
    import afe_spi_pkg::*;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic rst_a, rst_bc;
    int   n_pass = 0;
    int   n_total = 0;

    // instance a: defaults
    logic        a_valid, a_ready, a_rsp, a_busy, a_sclk, a_mosi, a_miso, a_ssel;
    logic [15:0] a_wdata, a_rdata, a_slave;
    logic [1:0]  a_csel, a_sel;
    int          a_rises = 0;
    logic        a_prev = 1'b0;

    // instance b: 8-bit, LSB first, CLK_DIV=1
    logic        b_valid, b_ready, b_rsp, b_busy, b_sclk, b_mosi, b_miso, b_ssel;
    logic [7:0]  b_wdata, b_rdata, b_slave;
    logic [1:0]  b_csel, b_sel;
    int          b_rises = 0;
    logic        b_prev = 1'b0;

    // instance c: 4 selects, 5-cycle latch, MISO tied high
    logic        c_valid, c_ready, c_rsp, c_busy, c_sclk, c_mosi, c_ssel;
    logic [15:0] c_wdata, c_rdata;
    logic [3:0]  c_csel, c_sel;

    afe_spi_link u_a (
        .sys_clk(sys_clk), .sys_rst(rst_a), .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_wdata(a_wdata), .cmd_sel(a_csel), .rsp_valid(a_rsp), .rsp_rdata(a_rdata),
        .busy(a_busy), .spi_clk_o(a_sclk), .spi_mosi_o(a_mosi), .spi_miso_i(a_miso),
        .spi_sel(a_ssel), .sel_o(a_sel)
    );

    afe_spi_link #(.DATA_W(8), .CLK_DIV(1), .LSB_FIRST(1'b1)) u_b (
        .sys_clk(sys_clk), .sys_rst(rst_bc), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_wdata(b_wdata), .cmd_sel(b_csel), .rsp_valid(b_rsp), .rsp_rdata(b_rdata),
        .busy(b_busy), .spi_clk_o(b_sclk), .spi_mosi_o(b_mosi), .spi_miso_i(b_miso),
        .spi_sel(b_ssel), .sel_o(b_sel)
    );

    afe_spi_link #(.N_SEL(4), .LATCH_CYC(5)) u_c (
        .sys_clk(sys_clk), .sys_rst(rst_bc), .cmd_valid(c_valid), .cmd_ready(c_ready),
        .cmd_wdata(c_wdata), .cmd_sel(c_csel), .rsp_valid(c_rsp), .rsp_rdata(c_rdata),
        .busy(c_busy), .spi_clk_o(c_sclk), .spi_mosi_o(c_mosi), .spi_miso_i(1'b1),
        .spi_sel(c_ssel), .sel_o(c_sel)
    );

    // Slaves present the next bit after each observed SPI clock rise.
    always @(negedge sys_clk) begin
        if (!a_busy) a_rises = 0;
        else if (a_sclk && !a_prev) a_rises++;
        a_prev = a_sclk;
        if (!b_busy) b_rises = 0;
        else if (b_sclk && !b_prev) b_rises++;
        b_prev = b_sclk;
    end
    assign a_miso = (a_rises < 16) ? a_slave[4'(15 - a_rises)] : 1'b0;
    assign b_miso = (b_rises < 8) ? b_slave[3'(b_rises)] : 1'b0;

    task automatic step();
        @(negedge sys_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    int          rises, hi, hibad, selbad, sscnt, ssfirst, rspk, rspk2, rspcnt, bad;
    logic        prev, ready_s, busy_s, first_mosi;
    logic [15:0] mbits, mbits2, rdat, rdat2;
    logic [3:0]  sel_done;

    initial begin
        rst_a = 1'b1; rst_bc = 1'b1;
        a_valid = 1'b0; a_wdata = '0; a_csel = '0; a_slave = 16'h3C5A;
        b_valid = 1'b0; b_wdata = '0; b_csel = '0; b_slave = 8'h80;
        c_valid = 1'b0; c_wdata = '0; c_csel = '0;
        repeat (3) step();
        rst_a = 1'b0; rst_bc = 1'b0;
        step();

        check("rst_ready", a_ready, 1);
        check("rst_outs", {a_rsp, a_busy, a_sclk, a_mosi, a_ssel, a_sel}, 0);
        check("rst_rdata", a_rdata, 0);

        bad = 0;
        repeat (100) begin
            step();
            if (a_sclk || a_mosi || a_ssel || a_sel != 0 || a_rsp || a_busy || !a_ready) bad++;
            if (b_sclk || b_ssel || b_rsp || c_sclk || c_ssel || c_rsp) bad++;
        end
        check("idle_quiet", bad, 0);

        // A5C3 out MSB first, slave answers 3C5A; a pulse during SHIFT is ignored
        a_wdata = 16'hA5C3; a_csel = 2'b10; a_valid = 1'b1;
        rises = 0; hi = 0; hibad = 0; selbad = 0; sscnt = 0; ssfirst = 0;
        rspk = 0; rspcnt = 0; prev = 1'b0; mbits = '0; rdat = '0; sel_done = '0;
        for (int k = 1; k <= 75; k++) begin
            step();
            if (k == 1) begin ready_s = a_ready; busy_s = a_busy; a_valid = 1'b0; end
            if (k == 10) begin a_valid = 1'b1; a_wdata = 16'hFFFF; end
            if (k == 11) a_valid = 1'b0;
            if (a_sclk && !prev) begin rises++; mbits = {mbits[14:0], a_mosi}; end
            if (a_sclk) hi++;
            else begin
                if (prev && hi != 2) hibad++;
                hi = 0;
            end
            prev = a_sclk;
            if (k <= 66 && a_sel != 2'b10) selbad++;
            if (a_ssel) begin sscnt++; if (ssfirst == 0) ssfirst = k; end
            if (a_rsp) begin
                rspcnt++;
                if (rspk == 0) begin rspk = k; rdat = a_rdata; sel_done = 4'(a_sel); end
            end
            if (k == 70) check("pulse_ignored_busy", a_busy, 0);
        end
        check("t1_ready_after_accept", ready_s, 0);
        check("t1_busy_after_accept", busy_s, 1);
        check("t1_mosi_bits", mbits, 16'hA5C3);
        check("t1_rises", rises, 16);
        check("t1_high_width", hibad, 0);
        check("t1_sel_held", selbad, 0);
        check("t1_spi_sel_width", sscnt, 2);
        check("t1_spi_sel_start", ssfirst, 65);
        check("t1_rsp_time", rspk, 67);
        check("t1_rsp_count", rspcnt, 1);
        check("t1_rdata", rdat, 16'h3C5A);
        check("t1_sel_in_done", sel_done, 0);
        check("t1_rdata_hold", a_rdata, 16'h3C5A);

        // back-to-back with cmd_valid held across two commands
        a_wdata = 16'h1234; a_slave = 16'h0F0F; a_valid = 1'b1;
        rspk = 0; rspk2 = 0; rspcnt = 0; prev = 1'b0; mbits2 = '0; rdat = '0; rdat2 = '0;
        for (int k = 1; k <= 140; k++) begin
            step();
            if (k == 1) a_wdata = 16'hBEEF;
            if (k == 67) check("b2b_ready_in_done", a_ready, 0);
            if (k == 68) begin check("b2b_ready_after_done", a_ready, 1); a_slave = 16'hC001; end
            if (k == 69) begin check("b2b_second_accept", a_busy, 1); a_valid = 1'b0; end
            if (k >= 69 && a_sclk && !prev) mbits2 = {mbits2[14:0], a_mosi};
            prev = a_sclk;
            if (a_rsp) begin
                rspcnt++;
                if (rspk == 0) begin rspk = k; rdat = a_rdata; end
                else begin rspk2 = k; rdat2 = a_rdata; end
            end
        end
        check("b2b_rsp1_time", rspk, 67);
        check("b2b_rsp2_time", rspk2, 135);
        check("b2b_rsp_count", rspcnt, 2);
        check("b2b_rdata1", rdat, 16'h0F0F);
        check("b2b_rdata2", rdat2, 16'hC001);
        check("b2b_mosi2", mbits2, 16'hBEEF);

        // reset during bit 5 of SHIFT
        a_wdata = 16'h5555; a_csel = 2'b11; a_valid = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            step();
            if (k == 1) a_valid = 1'b0;
        end
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        check("abort_sclk", a_sclk, 0);
        check("abort_spi_sel", a_ssel, 0);
        check("abort_sel", a_sel, 0);
        check("abort_ready", a_ready, 1);
        check("abort_busy", a_busy, 0);
        check("abort_rdata", a_rdata, 0);
        bad = 0;
        repeat (80) begin
            step();
            if (a_rsp || a_ssel || a_busy || a_sclk) bad++;
        end
        check("abort_no_rsp", bad, 0);

        // LSB first, 8 bits, CLK_DIV=1
        b_wdata = 8'h01; b_valid = 1'b1;
        rises = 0; hi = 0; hibad = 0; rspk = 0; prev = 1'b0; mbits = '0; rdat = '0;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (k == 1) begin first_mosi = b_mosi; b_valid = 1'b0; end
            if (b_sclk && !prev) begin rises++; mbits = {mbits[14:0], b_mosi}; end
            if (b_sclk) hi++;
            else begin
                if (prev && hi != 1) hibad++;
                hi = 0;
            end
            prev = b_sclk;
            if (b_rsp && rspk == 0) begin rspk = k; rdat = 16'(b_rdata); end
        end
        check("lsb_first_mosi", first_mosi, 1);
        check("lsb_mosi_bits", mbits[7:0], 8'h80);
        check("lsb_rises", rises, 8);
        check("lsb_high_width", hibad, 0);
        check("lsb_rsp_time", rspk, 19);
        check("lsb_rdata", rdat, 16'h0080);

        // four selects, five-cycle latch strobe
        c_wdata = 16'h0F0F; c_csel = 4'b1001; c_valid = 1'b1;
        selbad = 0; sscnt = 0; ssfirst = 0; rspk = 0; rdat = '0; sel_done = 4'hF;
        for (int k = 1; k <= 75; k++) begin
            step();
            if (k == 1) c_valid = 1'b0;
            if (k <= 69 && c_sel != 4'b1001) selbad++;
            if (c_ssel) begin sscnt++; if (ssfirst == 0) ssfirst = k; end
            if (c_rsp && rspk == 0) begin rspk = k; rdat = c_rdata; sel_done = c_sel; end
        end
        check("nsel_sel_held", selbad, 0);
        check("nsel_sel_in_done", sel_done, 0);
        check("nsel_spi_sel_width", sscnt, 5);
        check("nsel_spi_sel_start", ssfirst, 65);
        check("nsel_rsp_time", rspk, afe_spi_latency(16, 2, 5));
        check("nsel_rdata", rdat, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
